// File: rtl/msg_seq_pkg.sv
// Shared types and constants for the UART message sequencer.
// The optional CR/LF trailer is enabled by defining MSG_SEQ_CRLF_EN.
package msg_seq_pkg;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // S_CR / S_LF load the trailer bytes; they are only reachable with MSG_SEQ_CRLF_EN.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CONV = 4'd1,
    S_ADDR = 4'd2,
    S_ROMW = 4'd3,
    S_TXW  = 4'd4,
    S_HOLD = 4'd5,
    S_FIN  = 4'd6,
    S_CR   = 4'd7,
    S_LF   = 4'd8
  } msg_state_e;

endpackage

// File: rtl/uart_message_sequencer_tx_byte_issuer.sv
// Byte handshake towards serial_tx: a byte offered with valid is accepted
// as soon as serial_tx is idle. Acceptance registers the byte onto tx_data
// and raises tx_new_data for exactly one cycle (the sequencer's HOLD cycle).
module tx_byte_issuer
  import msg_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_new_data,
  output logic       accepted
);

  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_new_data_q, tx_new_data_d;

  // Handshake: valid is held by the sequencer until accepted; accepted is valid && !tx_busy.
  assign accepted = valid & ~tx_busy;

  // Capture the byte and generate the single-cycle strobe on acceptance.
  always_comb begin
    tx_data_d     = tx_data_q;
    tx_new_data_d = accepted;
    if (accepted) tx_data_d = byte_in;
  end

  // Strobe and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q     <= 8'h00;
      tx_new_data_q <= 1'b0;
    end else begin
      tx_data_q     <= tx_data_d;
      tx_new_data_q <= tx_new_data_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_new_data = tx_new_data_q;

endmodule

// File: rtl/uart_message_sequencer.sv
// Message sequencer: starts the BCD conversion, waits for it (with timeout),
// then reads ROM addresses MSG_LEN..1 and pushes each byte to serial_tx.
// Define MSG_SEQ_CRLF_EN to append CR LF after the ROM bytes.
module uart_message_sequencer
  import msg_seq_pkg::*;
#(
  parameter int MSG_LEN      = 4,
  parameter int ROM_LATENCY  = 1,
  parameter int CONV_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       conv_err,
  output logic       conv_start,
  input  logic       conv_done,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] tx_data,
  output logic       tx_new_data,
  input  logic       tx_busy,
  output logic [3:0] dbg_state
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(MSG_LEN);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  WAIT_LOAD  = CNT_W'(ROM_LATENCY);
  localparam logic [CNT_W-1:0]  TMO_LAST   = CNT_W'(CONV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  msg_state_e        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              conv_err_q, conv_err_d;
  logic              conv_start_q, conv_start_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        byte_q, byte_d;
  logic              tx_valid;
  logic              tx_accepted;
`ifdef MSG_SEQ_CRLF_EN
  // 0: ROM bytes, 1: CR issued, 2: LF issued.
  logic [1:0]        tail_q, tail_d;
`endif

  // Next-state and registered-output logic for the message FSM.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    conv_err_d   = conv_err_q;
    conv_start_d = 1'b0;
    rom_addr_d   = rom_addr_q;
    wait_d       = wait_q;
    tmo_d        = tmo_q;
    byte_d       = byte_q;
    tx_valid     = 1'b0;
`ifdef MSG_SEQ_CRLF_EN
    tail_d       = tail_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (send) begin
          state_d      = S_CONV;
          busy_d       = 1'b1;
          conv_start_d = 1'b1;
          conv_err_d   = 1'b0;
          tmo_d        = '0;
`ifdef MSG_SEQ_CRLF_EN
          tail_d       = 2'd0;
`endif
        end
      end
      S_CONV: begin
        if (conv_done) begin
          state_d = S_ADDR;
        end else if (tmo_q == TMO_LAST) begin
          conv_err_d = 1'b1;
          state_d    = S_ADDR;
        end else begin
          tmo_d = tmo_q + CNT_ONE;
        end
      end
      S_ADDR: begin
        rom_addr_d = FIRST_ADDR;
        wait_d     = WAIT_LOAD;
        state_d    = S_ROMW;
      end
      S_ROMW: begin
        if (wait_q == '0) begin
          byte_d  = rom_data;
          state_d = S_TXW;
        end else begin
          wait_d = wait_q - CNT_ONE;
        end
      end
      S_TXW: begin
        tx_valid = 1'b1;
        if (tx_accepted) state_d = S_HOLD;
      end
      S_HOLD: begin
`ifdef MSG_SEQ_CRLF_EN
        if (tail_q == 2'd2) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (tail_q == 2'd1) begin
          state_d = S_LF;
        end else if (rom_addr_q == ADDR_ONE) begin
          state_d = S_CR;
        end else begin
          rom_addr_d = rom_addr_q - ADDR_ONE;
          wait_d     = WAIT_LOAD;
          state_d    = S_ROMW;
        end
`else
        if (rom_addr_q == ADDR_ONE) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          rom_addr_d = rom_addr_q - ADDR_ONE;
          wait_d     = WAIT_LOAD;
          state_d    = S_ROMW;
        end
`endif
      end
      S_FIN: begin
        // done/busy were set on entry; sends seen here are dropped.
        state_d = S_IDLE;
      end
`ifdef MSG_SEQ_CRLF_EN
      S_CR: begin
        byte_d  = ASCII_CR;
        tail_d  = 2'd1;
        state_d = S_TXW;
      end
      S_LF: begin
        byte_d  = ASCII_LF;
        tail_d  = 2'd2;
        state_d = S_TXW;
      end
`endif
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      conv_err_q   <= 1'b0;
      conv_start_q <= 1'b0;
      rom_addr_q   <= '0;
      wait_q       <= '0;
      tmo_q        <= '0;
      byte_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      conv_err_q   <= conv_err_d;
      conv_start_q <= conv_start_d;
      rom_addr_q   <= rom_addr_d;
      wait_q       <= wait_d;
      tmo_q        <= tmo_d;
      byte_q       <= byte_d;
    end
  end

`ifdef MSG_SEQ_CRLF_EN
  // Trailer phase tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tail_q <= 2'd0;
    else        tail_q <= tail_d;
  end
`endif

  tx_byte_issuer u_tx_byte_issuer (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_in     (byte_q),
    .valid       (tx_valid),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_new_data (tx_new_data),
    .accepted    (tx_accepted)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign conv_err   = conv_err_q;
  assign conv_start = conv_start_q;
  assign rom_addr   = rom_addr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_message_sequencer.sv
// Directed testbench for uart_message_sequencer with ROM, converter and
// serial_tx models. Build with MSG_SEQ_CRLF_EN to expect the CR LF trailer.
module tb_uart_message_sequencer;
  import msg_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send = 1'b0;
  logic       busy, done, conv_err, conv_start;
  logic       conv_done = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_new_data;
  logic       tx_busy = 1'b0;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  uart_message_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .send        (send),
    .busy        (busy),
    .done        (done),
    .conv_err    (conv_err),
    .conv_start  (conv_start),
    .conv_done   (conv_done),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .tx_data     (tx_data),
    .tx_new_data (tx_new_data),
    .tx_busy     (tx_busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- models ----------------
  logic [7:0] rom_mem [0:255];
  int         conv_delay = 5;
  bit         conv_en = 1'b1;
  int         ccnt = 0;
  int         tx_len = 10;
  int         txcnt = 0;
  logic [7:0] rx_q[$];
  int         done_cnt = 0;

  // Registered ROM: one cycle from address to data.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Converter and serial_tx models, plus capture of strobed bytes and done pulses.
  always @(negedge clk) begin
    if (conv_start) begin
      ccnt = conv_delay;
      conv_done = 1'b0;
    end else if (ccnt != 0) begin
      ccnt = ccnt - 1;
      conv_done = (ccnt == 0) && conv_en;
    end else begin
      conv_done = 1'b0;
    end
    if (tx_new_data) begin
      rx_q.push_back(tx_data);
      txcnt = tx_len;
    end else if (txcnt != 0) begin
      txcnt = txcnt - 1;
    end
    tx_busy = (txcnt != 0);
    if (done) done_cnt = done_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int pass_cnt = 0;
  int total = 0;

  task automatic set_rom(input logic [31:0] v);
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'hEE;
    rom_mem[4] = v[31:24];
    rom_mem[3] = v[23:16];
    rom_mem[2] = v[15:8];
    rom_mem[1] = v[7:0];
    exp_q = {};
    exp_q.push_back(v[31:24]);
    exp_q.push_back(v[23:16]);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
`ifdef MSG_SEQ_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  // ---------------- drivers ----------------
  // Returns on the negedge of the cycle in which conv_start is high.
  task automatic pulse_send();
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0 || conv_start !== 1'b0) $display("FAIL reset_pulses: got done=%b conv_start=%b want 0", done, conv_start); else pass_cnt++;
    total++; if (conv_err !== 1'b0) $display("FAIL reset_conv_err: got %b want 0", conv_err); else pass_cnt++;
    total++; if (tx_new_data !== 1'b0) $display("FAIL reset_tx_new_data: got %b want 0", tx_new_data); else pass_cnt++;
    total++; if (rom_addr !== 8'h00 || tx_data !== 8'h00) $display("FAIL reset_addr_data: got addr=%h data=%h want 00", rom_addr, tx_data); else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_basic();
    int base, dbase;
    bit ok;
    set_rom(32'h41424344);
    conv_en = 1'b1; conv_delay = 5; tx_len = 10;
    base = rx_q.size(); dbase = done_cnt;
    pulse_send();
    total++; if (conv_start !== 1'b1 || busy !== 1'b1) $display("FAIL basic_start: got conv_start=%b busy=%b want 1 1", conv_start, busy); else pass_cnt++;
    @(negedge clk);
    total++; if (conv_start !== 1'b0) $display("FAIL basic_start_pulse: got %b want 0", conv_start); else pass_cnt++;
    wait_done(3000, ok);
    total++; if (!ok) $display("FAIL basic_done_timeout: got no done want done"); else pass_cnt++;
    repeat (3) @(negedge clk);
    total++; if (rx_q.size() - base !== exp_q.size()) $display("FAIL basic_count: got %0d want %0d", rx_q.size() - base, exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
      total++; if (rx_q[base+i] !== exp_q[i]) $display("FAIL basic_byte%0d: got %h want %h", i, rx_q[base+i], exp_q[i]); else pass_cnt++;
    end
    total++; if (done_cnt - dbase !== 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt - dbase); else pass_cnt++;
    total++; if (conv_err !== 1'b0 || busy !== 1'b0) $display("FAIL basic_end_flags: got conv_err=%b busy=%b want 0 0", conv_err, busy); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int base, n;
    bit ok;
    set_rom(32'h55AA0F01);
    conv_en = 1'b0; tx_len = 10;
    base = rx_q.size();
    pulse_send();
    n = 0;
    while (conv_err !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== 64) $display("FAIL timeout_cycles: got %0d want 64", n); else pass_cnt++;
    wait_done(3000, ok);
    total++; if (!ok) $display("FAIL timeout_done: got no done want done"); else pass_cnt++;
    repeat (2) @(negedge clk);
    total++; if (rx_q.size() - base !== exp_q.size()) $display("FAIL timeout_count: got %0d want %0d", rx_q.size() - base, exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
      total++; if (rx_q[base+i] !== exp_q[i]) $display("FAIL timeout_byte%0d: got %h want %h", i, rx_q[base+i], exp_q[i]); else pass_cnt++;
    end
    total++; if (conv_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", conv_err); else pass_cnt++;
    conv_en = 1'b1;
    pulse_send();
    total++; if (conv_err !== 1'b0) $display("FAIL timeout_clear: got %b want 0", conv_err); else pass_cnt++;
    wait_done(3000, ok);
    total++; if (!ok || conv_err !== 1'b0) $display("FAIL timeout_rerun: got ok=%b conv_err=%b want 1 0", ok, conv_err); else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_colon();
    int base;
    bit ok;
    set_rom(32'h3A3A3A3A);
    base = rx_q.size();
    pulse_send();
    wait_done(3000, ok);
    repeat (2) @(negedge clk);
    total++; if (!ok || rx_q.size() - base !== exp_q.size()) $display("FAIL colon_count: got ok=%b n=%0d want 1 %0d", ok, rx_q.size() - base, exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
      total++; if (rx_q[base+i] !== exp_q[i]) $display("FAIL colon_byte%0d: got %h want %h", i, rx_q[base+i], exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_min_timing();
    int n, want;
    set_rom(32'h01020304);
    tx_len = 0; conv_delay = 5;
`ifdef MSG_SEQ_CRLF_EN
    want = 29;
`else
    want = 23;
`endif
    pulse_send();
    n = 0;
    while (done !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== want) $display("FAIL min_timing: got %0d want %0d", n, want); else pass_cnt++;
    repeat (2) @(negedge clk);
    tx_len = 10;
  endtask

  task automatic test_back_to_back();
    int base, dbase;
    bit ok;
    set_rom(32'h61626364);
    base = rx_q.size(); dbase = done_cnt;
    pulse_send();
    for (int k = 0; k < 3; k++) begin
      repeat (7) @(negedge clk);
      pulse_send();
    end
    wait_done(3000, ok);
    repeat (80) @(negedge clk);
    total++; if (!ok || done_cnt - dbase !== 1) $display("FAIL b2b_done_count: got ok=%b n=%0d want 1 1", ok, done_cnt - dbase); else pass_cnt++;
    total++; if (rx_q.size() - base !== exp_q.size()) $display("FAIL b2b_byte_count: got %0d want %0d", rx_q.size() - base, exp_q.size()); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_idle: got busy=%b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int base, base2, dbase2, n;
    bit ok;
    set_rom(32'h41424344);
    tx_len = 10;
    base = rx_q.size();
    pulse_send();
    n = 0;
    while (!((rx_q.size() - base == 2) && (dbg_state == 4'(S_TXW))) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++; if (n >= 1000) $display("FAIL rstmid_reach_txw: got timeout want third byte TXW"); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || conv_start !== 1'b0) $display("FAIL rstmid_ctrl: got busy=%b done=%b conv_start=%b want 0", busy, done, conv_start); else pass_cnt++;
    total++; if (rom_addr !== 8'h00 || tx_data !== 8'h00 || tx_new_data !== 1'b0) $display("FAIL rstmid_data: got addr=%h data=%h new=%b want 0", rom_addr, tx_data, tx_new_data); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base2 = rx_q.size(); dbase2 = done_cnt;
    repeat (60) @(negedge clk);
    total++; if (rx_q.size() !== base2 || done_cnt !== dbase2) $display("FAIL rstmid_quiet: got bytes=%0d done=%0d want 0 0", rx_q.size() - base2, done_cnt - dbase2); else pass_cnt++;
    pulse_send();
    wait_done(3000, ok);
    repeat (2) @(negedge clk);
    total++; if (!ok || rx_q.size() - base2 !== exp_q.size()) $display("FAIL rstmid_recover: got ok=%b n=%0d want 1 %0d", ok, rx_q.size() - base2, exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && base2 + i < rx_q.size(); i++) begin
      total++; if (rx_q[base2+i] !== exp_q[i]) $display("FAIL rstmid_byte%0d: got %h want %h", i, rx_q[base2+i], exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_crlf();
    int base;
    bit ok;
    set_rom(32'h30313233);
    base = rx_q.size();
    pulse_send();
    wait_done(3000, ok);
    repeat (2) @(negedge clk);
    total++; if (!ok || rx_q.size() - base !== exp_q.size()) $display("FAIL crlf_count: got ok=%b n=%0d want 1 %0d", ok, rx_q.size() - base, exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
      total++; if (rx_q[base+i] !== exp_q[i]) $display("FAIL crlf_byte%0d: got %h want %h", i, rx_q[base+i], exp_q[i]); else pass_cnt++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_rom(32'h00000000);
    test_reset();
    test_basic();
    test_timeout();
    test_colon();
    test_min_timing();
    test_back_to_back();
    test_reset_mid();
    test_crlf();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
